// File: rtl/regfile_sequencer.sv
// Multi-cycle ALU sequencer for a 4 x 16-bit, 2-read/1-write register file.
// Each command runs as IDLE -> READ -> EXEC -> WRITE; the write-back port is owned here alone.
module regfile_sequencer (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_op_i,
  input  logic [1:0]  cmd_rd_i,
  input  logic [1:0]  cmd_rs1_i,
  input  logic [1:0]  cmd_rs2_i,
  input  logic [15:0] cmd_imm_i,
  output logic [1:0]  rf_out1_sel_o,
  output logic [1:0]  rf_out2_sel_o,
  input  logic [15:0] rf_out1_i,
  input  logic [15:0] rf_out2_i,
  output logic [15:0] rf_in_o,
  output logic [1:0]  rf_in_sel_o,
  output logic        rf_in_en_o,
  output logic        done_o,
  output logic [15:0] result_o,
  output logic        zero_o,
  output logic        carry_o,
  output logic [1:0]  state_o
);

  // Handshake: a command transfers on a rising edge where cmd_valid_i and
  // cmd_ready_o are both high; cmd_ready_o is high only in IDLE outside reset,
  // and cmd_valid_i is ignored whenever cmd_ready_o is low.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_LI   = 3'd5,
    OP_ADDI = 3'd6,
    OP_MOV  = 3'd7
  } op_t;

  state_t      state_q, state_d;
  logic        capture, read_en, exec_en, write_en;

  logic [2:0]  op_q;
  logic [1:0]  rd_q, rs1_q, rs2_q;
  logic [15:0] imm_q;
  logic [15:0] a_q, b_q;
  logic [16:0] res_q;
  logic [16:0] alu_res;
  logic [1:0]  in_sel_q;
  logic [15:0] result_q;
  logic        zero_q, carry_q;

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    read_en  = 1'b0;
    exec_en  = 1'b0;
    write_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          capture = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        read_en = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        exec_en = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        write_en = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit 16 carries the carry-out for ADD/ADDI and the borrow for SUB.
  always_comb begin
    alu_res = 17'd0;
    case (op_t'(op_q))
      OP_ADD:  alu_res = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  alu_res = {1'b0, a_q} - {1'b0, b_q};
      OP_AND:  alu_res = {1'b0, a_q & b_q};
      OP_OR:   alu_res = {1'b0, a_q | b_q};
      OP_XOR:  alu_res = {1'b0, a_q ^ b_q};
      OP_LI:   alu_res = {1'b0, imm_q};
      OP_ADDI: alu_res = {1'b0, a_q} + {1'b0, imm_q};
      OP_MOV:  alu_res = {1'b0, a_q};
      default: alu_res = 17'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      op_q     <= 3'd0;
      rd_q     <= 2'd0;
      rs1_q    <= 2'd0;
      rs2_q    <= 2'd0;
      imm_q    <= 16'd0;
      a_q      <= 16'd0;
      b_q      <= 16'd0;
      res_q    <= 17'd0;
      in_sel_q <= 2'd0;
      result_q <= 16'd0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        op_q  <= cmd_op_i;
        rd_q  <= cmd_rd_i;
        rs1_q <= cmd_rs1_i;
        rs2_q <= cmd_rs2_i;
        imm_q <= cmd_imm_i;
      end
      // Operands are taken before the write-back, so rd == rs sees the old value.
      if (read_en) begin
        a_q <= rf_out1_i;
        b_q <= rf_out2_i;
      end
      // The write-back select is latched here so it stays put when the next command is captured.
      if (exec_en) begin
        res_q    <= alu_res;
        in_sel_q <= rd_q;
      end
      if (write_en) begin
        result_q <= res_q[15:0];
        zero_q   <= (res_q[15:0] == 16'd0);
        carry_q  <= res_q[16];
      end
    end
  end

  assign cmd_ready_o   = (state_q == ST_IDLE) && !reset_i;
  assign rf_out1_sel_o = rs1_q;
  assign rf_out2_sel_o = rs2_q;
  assign rf_in_o       = res_q[15:0];
  assign rf_in_sel_o   = in_sel_q;
  assign rf_in_en_o    = write_en;
  assign done_o        = write_en;
  assign result_o      = result_q;
  assign zero_o        = zero_q;
  assign carry_o       = carry_q;
  assign state_o       = state_q;

  a_write_then_idle: assert property (@(posedge clk) disable iff (reset_i)
    rf_in_en_o |=> (state_q == ST_IDLE));
  a_ready_only_idle: assert property (@(posedge clk)
    cmd_ready_o |-> (state_q == ST_IDLE));

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural register file, reference ALU model
// and a scoreboard of expected write-backs checked whenever done_o pulses.
module tb_regfile_sequencer;

  localparam int W = 35;  // {accept_cycle[15:0], carry, sel[1:0], data[15:0]}

  logic        clk = 1'b0;
  logic        reset_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [2:0]  cmd_op_i;
  logic [1:0]  cmd_rd_i, cmd_rs1_i, cmd_rs2_i;
  logic [15:0] cmd_imm_i;
  logic [1:0]  rf_out1_sel_o, rf_out2_sel_o;
  logic [15:0] rf_out1_i, rf_out2_i;
  logic [15:0] rf_in_o;
  logic [1:0]  rf_in_sel_o;
  logic        rf_in_en_o;
  logic        done_o;
  logic [15:0] result_o;
  logic        zero_o, carry_o;
  logic [1:0]  state_o;

  regfile_sequencer dut (
    .clk(clk), .reset_i(reset_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_rd_i(cmd_rd_i), .cmd_rs1_i(cmd_rs1_i),
    .cmd_rs2_i(cmd_rs2_i), .cmd_imm_i(cmd_imm_i),
    .rf_out1_sel_o(rf_out1_sel_o), .rf_out2_sel_o(rf_out2_sel_o),
    .rf_out1_i(rf_out1_i), .rf_out2_i(rf_out2_i),
    .rf_in_o(rf_in_o), .rf_in_sel_o(rf_in_sel_o), .rf_in_en_o(rf_in_en_o),
    .done_o(done_o), .result_o(result_o), .zero_o(zero_o), .carry_o(carry_o),
    .state_o(state_o)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- register file model ----------------
  logic [15:0] rf [4];
  logic [15:0] gold [4];
  initial for (int i = 0; i < 4; i++) begin rf[i] = 16'd0; gold[i] = 16'd0; end
  always @(posedge clk) if (rf_in_en_o) rf[rf_in_sel_o] <= rf_in_o;
  assign rf_out1_i = rf[rf_out1_sel_o];
  assign rf_out2_i = rf[rf_out2_sel_o];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [16:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] imm);
    int s;
    case (op)
      3'd0: begin s = int'(a) + int'(b);   return s[16:0]; end
      3'd1: return {(a < b), 16'(a - b)};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, imm};
      3'd6: begin s = int'(a) + int'(imm); return s[16:0]; end
      default: return {1'b0, a};
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] post_exp;
  bit           post_pending = 0;
  int           done_count = 0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [15:0]  lat;
    if (reset_i) begin
      post_pending = 0;
    end else begin
      if (post_pending) begin
        check_eq("result_o", result_o, post_exp[15:0]);
        check_eq("zero_o", zero_o, post_exp[15:0] == 16'd0);
        check_eq("carry_o", carry_o, post_exp[18]);
        check_eq("ready_after_write", cmd_ready_o, 1);
        post_pending = 0;
      end
      check_eq("en_vs_done", rf_in_en_o, done_o);
      if (done_o) begin
        done_count++;
        check_eq("ready_in_write", cmd_ready_o, 0);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_done", done_o, 0);
        end else begin
          e   = exp_q.pop_front();
          lat = cyc[15:0] - e[34:19];
          check_eq("write_latency", lat, 3);
          check_eq("rf_in_sel", rf_in_sel_o, e[17:16]);
          check_eq("rf_in_data", rf_in_o, e[15:0]);
          post_exp     = e;
          post_pending = 1;
        end
      end
    end
  end

  // ---------------- driver ----------------
  int last_wait;
  int last_acc;

  task automatic send_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                          input logic [1:0] rs2, input logic [15:0] imm,
                          input bit push, input bit keep);
    int waited;
    logic [16:0] r;
    cmd_op_i = op; cmd_rd_i = rd; cmd_rs1_i = rs1; cmd_rs2_i = rs2; cmd_imm_i = imm;
    cmd_valid_i = 1'b1;
    waited = 0;
    while (!cmd_ready_o && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("accept_ready", cmd_ready_o, 1);
    if (!cmd_ready_o) begin
      cmd_valid_i = 1'b0;
      return;
    end
    last_wait = waited;
    last_acc  = cyc;
    if (push) begin
      r = ref_alu(op, gold[rs1], gold[rs2], imm);
      gold[rd] = r[15:0];
      exp_q.push_back({cyc[15:0], r[16], rd, r[15:0]});
    end
    @(negedge clk);
    if (!keep) cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || post_pending) && t < 60) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_queue", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] sweep_tab [8];
  int prev_acc;

  initial begin
    sweep_tab[0] = 16'h100E; sweep_tab[1] = 16'h0E10; sweep_tab[2] = 16'h000F;
    sweep_tab[3] = 16'h0FFF; sweep_tab[4] = 16'h0FF0; sweep_tab[5] = 16'h0101;
    sweep_tab[6] = 16'h1010; sweep_tab[7] = 16'h0F0F;

    reset_i = 1'b1; cmd_valid_i = 1'b0;
    cmd_op_i = 3'd0; cmd_rd_i = 2'd0; cmd_rs1_i = 2'd0; cmd_rs2_i = 2'd0; cmd_imm_i = 16'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", cmd_ready_o, 0);
    check_eq("rst_state", state_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_en", rf_in_en_o, 0);
    check_eq("rst_result", {zero_o, carry_o, result_o}, 0);
    check_eq("rst_sels", {rf_out1_sel_o, rf_out2_sel_o, rf_in_sel_o}, 0);
    check_eq("rst_rf_in", rf_in_o, 0);
    reset_i = 1'b0;
    #1 check_eq("ready_after_rst", cmd_ready_o, 1);
    @(negedge clk);

    // LI after reset
    send_cmd(3'd5, 2'd1, 2'd0, 2'd0, 16'h1234, 1, 0);
    drain();
    check_eq("li_done_once", done_count, 1);

    // ADD with carry out, zero result
    send_cmd(3'd5, 2'd1, 2'd0, 2'd0, 16'hFFFF, 1, 0);
    send_cmd(3'd5, 2'd2, 2'd0, 2'd0, 16'h0001, 1, 0);
    send_cmd(3'd0, 2'd3, 2'd1, 2'd2, 16'h0000, 1, 0);
    drain();
    check_eq("add_zero", zero_o, 1);
    check_eq("add_carry", carry_o, 1);

    // SUB borrow with rd == rs1
    send_cmd(3'd5, 2'd1, 2'd0, 2'd0, 16'h0005, 1, 0);
    send_cmd(3'd5, 2'd2, 2'd0, 2'd0, 16'h0007, 1, 0);
    send_cmd(3'd1, 2'd1, 2'd1, 2'd2, 16'h0000, 1, 0);
    drain();
    check_eq("sub_x1", rf[1], 16'hFFFE);
    check_eq("sub_carry", carry_o, 1);

    // valid held high across three commands
    send_cmd(3'd5, 2'd0, 2'd0, 2'd0, 16'h0F0F, 1, 1);
    prev_acc = last_acc;
    send_cmd(3'd5, 2'd1, 2'd0, 2'd0, 16'h00FF, 1, 1);
    check_eq("b2b_gap1", last_acc - prev_acc, 4);
    check_eq("b2b_notready1", last_wait, 3);
    prev_acc = last_acc;
    send_cmd(3'd0, 2'd2, 2'd0, 2'd1, 16'h0000, 1, 0);
    check_eq("b2b_gap2", last_acc - prev_acc, 4);
    check_eq("b2b_notready2", last_wait, 3);
    drain();
    check_eq("b2b_x2", rf[2], 16'h100E);

    // op sweep, x0/x1 already hold 0x0F0F/0x00FF
    for (int op = 0; op < 8; op++) begin
      send_cmd(op[2:0], 2'd3, 2'd0, 2'd1, 16'h0101, 1, 0);
      drain();
      check_eq($sformatf("sweep_op%0d", op), result_o, sweep_tab[op]);
      check_eq($sformatf("sweep_carry%0d", op), carry_o, 0);
    end

    // reset during EXEC of an ADDI
    done_count = 0;
    send_cmd(3'd6, 2'd1, 2'd2, 2'd3, 16'h0055, 0, 0);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_done", done_o, 0);
    check_eq("mid_rst_en", rf_in_en_o, 0);
    check_eq("mid_rst_result", {zero_o, carry_o, result_o}, 0);
    check_eq("mid_rst_sels", {rf_out1_sel_o, rf_out2_sel_o, rf_in_sel_o}, 0);
    check_eq("mid_rst_rf_in", rf_in_o, 0);
    check_eq("mid_rst_ready", cmd_ready_o, 0);
    reset_i = 1'b0;
    #1 check_eq("mid_rst_ready_after", cmd_ready_o, 1);
    @(negedge clk);
    check_eq("mid_rst_x1_kept", rf[1], gold[1]);
    check_eq("mid_rst_no_done", done_count, 0);
    send_cmd(3'd5, 2'd2, 2'd0, 2'd0, 16'hBEEF, 1, 0);
    drain();

    // random traffic
    for (int k = 0; k < 24; k++) begin
      send_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)), 1,
               1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    cmd_valid_i = 1'b0;
    drain();

    for (int i = 0; i < 4; i++) check_eq($sformatf("final_x%0d", i), rf[i], gold[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
